// File: rtl/lmc1992_pkg.sv
// Shared constants for the LMC1992 receive model: function codes, reset values,
// range limits and the gain mute threshold.
package lmc1992_pkg;

    localparam int FRAME_BITS = 11;

    localparam logic [2:0] LMC_FN_MIXER  = 3'b000;
    localparam logic [2:0] LMC_FN_BASS   = 3'b001;
    localparam logic [2:0] LMC_FN_TREBLE = 3'b010;
    localparam logic [2:0] LMC_FN_MASTER = 3'b011;
    localparam logic [2:0] LMC_FN_RIGHT  = 3'b100;
    localparam logic [2:0] LMC_FN_LEFT   = 3'b101;

    localparam logic [5:0] MASTER_MAX = 6'd40;
    localparam logic [4:0] CHAN_MAX   = 5'd20;
    localparam logic [3:0] TONE_MAX   = 4'd12;
    localparam logic [5:0] MUTE_K     = 6'd40;

    localparam logic [5:0] MASTER_RST  = 6'd40;
    localparam logic [4:0] CHAN_RST    = 5'd20;
    localparam logic [3:0] TONE_RST    = 4'd6;
    localparam logic [1:0] MIXER_RST   = 2'b01;
    localparam logic [7:0] SAMPLE_ZERO = 8'd128;

    // Clamp a wide signed intermediate to the signed 8-bit sample range.
    function automatic logic signed [7:0] sat8(input logic signed [17:0] v);
        if (v > 18'sd127)
            return 8'sh7f;
        else if (v < -18'sd128)
            return 8'sh80;
        else
            return v[7:0];
    endfunction

    function automatic logic [7:0] to_offset(input logic signed [7:0] y);
        return {~y[7], y[6:0]};
    endfunction

endpackage

// File: rtl/lmc1992_gain_rom.sv
// Attenuation lookup: k in 2 dB steps to a 9-bit linear gain, 256 = 0 dB.
// Anything at or beyond the mute threshold reads as zero.
module lmc1992_gain_rom
    import lmc1992_pkg::*;
(
    input  logic [5:0] k,
    output logic [8:0] g
);

    always_comb begin
        g = 9'd0;
        if (k < MUTE_K) begin
            case (k)
                6'd0:    g = 9'd256;
                6'd1:    g = 9'd203;
                6'd2:    g = 9'd162;
                6'd3:    g = 9'd128;
                6'd4:    g = 9'd102;
                6'd5:    g = 9'd81;
                6'd6:    g = 9'd64;
                6'd7:    g = 9'd51;
                6'd8:    g = 9'd41;
                6'd9:    g = 9'd32;
                6'd10:   g = 9'd26;
                6'd11:   g = 9'd20;
                6'd12:   g = 9'd16;
                6'd13:   g = 9'd13;
                6'd14:   g = 9'd10;
                6'd15:   g = 9'd8;
                6'd16:   g = 9'd6;
                6'd17:   g = 9'd5;
                6'd18:   g = 9'd4;
                6'd19:   g = 9'd3;
                6'd20:   g = 9'd3;
                6'd21:   g = 9'd2;
                6'd22:   g = 9'd2;
                6'd23:   g = 9'd1;
                6'd24:   g = 9'd1;
                6'd25:   g = 9'd1;
                6'd26:   g = 9'd1;
                6'd27:   g = 9'd1;
                6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33,
                6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                6'd40:   g = 9'd0;
                default: g = 9'd0;
            endcase
        end
    end

endmodule

// File: rtl/lmc1992_rx.sv
// LMC1992 receive side: microwire deserialiser, command decode and a two-stage
// attenuation pipeline. Define LMC1992_MIXER_EN to build the PSG mixing path.
module lmc1992_rx
    import lmc1992_pkg::*;
#(
    parameter logic [1:0] LMC_ADDR = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mw_bit_en,
    input  logic       mw_mask,
    input  logic       mw_data,
    input  logic       mw_done,
    input  logic       sample_en,
    input  logic [7:0] dma_l,
    input  logic [7:0] dma_r,
    input  logic [7:0] psg,
    output logic [7:0] out_l,
    output logic [7:0] out_r,
    output logic       out_valid,
    output logic       cmd_valid,
    output logic       cmd_err,
    output logic [5:0] master_vol,
    output logic [4:0] left_vol,
    output logic [4:0] right_vol,
    output logic [3:0] bass,
    output logic [3:0] treble,
    output logic [1:0] mixer
);

    logic [10:0] shifter, shifter_nxt, frame;
    logic [4:0]  bit_cnt, cnt_nxt, frame_cnt;
    logic        done_q, done_rise, close_pend;
    logic [2:0]  fn;
    logic [5:0]  d;
    logic        frame_ok;

    always_comb begin
        shifter_nxt = shifter;
        cnt_nxt     = bit_cnt;
        if (mw_bit_en && mw_mask) begin
            shifter_nxt = {shifter[9:0], mw_data};
            if (bit_cnt != 5'd31)
                cnt_nxt = bit_cnt + 5'd1;
        end
    end

    assign done_rise = mw_done & ~done_q;

    // A bit arriving with the closing edge is folded into the captured frame.
    always_ff @(posedge clk) begin
        done_q <= mw_done;
        if (reset) begin
            shifter    <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            frame_cnt  <= '0;
            close_pend <= 1'b0;
        end else begin
            close_pend <= done_rise;
            if (done_rise) begin
                frame     <= shifter_nxt;
                frame_cnt <= cnt_nxt;
                shifter   <= '0;
                bit_cnt   <= '0;
            end else begin
                shifter <= shifter_nxt;
                bit_cnt <= cnt_nxt;
            end
        end
    end

    assign fn       = frame[8:6];
    assign d        = frame[5:0];
    assign frame_ok = (frame_cnt >= 5'(FRAME_BITS)) && (frame[10:9] == LMC_ADDR)
                      && (fn <= LMC_FN_LEFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            master_vol <= MASTER_RST;
            left_vol   <= CHAN_RST;
            right_vol  <= CHAN_RST;
            bass       <= TONE_RST;
            treble     <= TONE_RST;
            mixer      <= MIXER_RST;
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (close_pend) begin
                if (!frame_ok) begin
                    cmd_err <= 1'b1;
                end else begin
                    cmd_valid <= 1'b1;
                    case (fn)
                        LMC_FN_MIXER:  mixer      <= d[1:0];
                        LMC_FN_BASS:   bass       <= (d[3:0] > TONE_MAX) ? TONE_MAX : d[3:0];
                        LMC_FN_TREBLE: treble     <= (d[3:0] > TONE_MAX) ? TONE_MAX : d[3:0];
                        LMC_FN_MASTER: master_vol <= (d > MASTER_MAX) ? MASTER_MAX : d;
                        LMC_FN_RIGHT:  right_vol  <= (d[4:0] > CHAN_MAX) ? CHAN_MAX : d[4:0];
                        LMC_FN_LEFT:   left_vol   <= (d[4:0] > CHAN_MAX) ? CHAN_MAX : d[4:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    logic signed [7:0] s_l, s_r, mix_l, mix_r;

    assign s_l = $signed(dma_l ^ 8'h80);
    assign s_r = $signed(dma_r ^ 8'h80);

`ifdef LMC1992_MIXER_EN
    logic signed [7:0] p, p_add;

    assign p = $signed(psg ^ 8'h80);

    always_comb begin
        case (mixer)
            2'b00:   p_add = p >>> 2;
            2'b01:   p_add = p;
            default: p_add = 8'sd0;
        endcase
    end

    assign mix_l = sat8(18'(s_l) + 18'(p_add));
    assign mix_r = sat8(18'(s_r) + 18'(p_add));
`else
    logic unused_psg;

    assign unused_psg = ^psg;
    assign mix_l      = s_l;
    assign mix_r      = s_r;
`endif

    logic [5:0]        k_l_nxt, k_r_nxt, k_l, k_r;
    logic signed [7:0] st1_l, st1_r;
    logic              st1_valid;

    assign k_l_nxt = (MASTER_MAX - master_vol) + 6'(CHAN_MAX - left_vol);
    assign k_r_nxt = (MASTER_MAX - master_vol) + 6'(CHAN_MAX - right_vol);

    // Attenuation is frozen with the sample so later commands cannot touch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            st1_valid <= 1'b0;
            st1_l     <= '0;
            st1_r     <= '0;
            k_l       <= '0;
            k_r       <= '0;
        end else begin
            st1_valid <= sample_en;
            if (sample_en) begin
                st1_l <= mix_l;
                st1_r <= mix_r;
                k_l   <= k_l_nxt;
                k_r   <= k_r_nxt;
            end
        end
    end

    logic [8:0]         g_l, g_r;
    logic signed [17:0] prod_l, prod_r, sh_l, sh_r;

    lmc1992_gain_rom u_rom_l (.k(k_l), .g(g_l));
    lmc1992_gain_rom u_rom_r (.k(k_r), .g(g_r));

    assign prod_l = 18'(st1_l) * 18'($signed({1'b0, g_l}));
    assign prod_r = 18'(st1_r) * 18'($signed({1'b0, g_r}));
    assign sh_l   = prod_l >>> 8;
    assign sh_r   = prod_r >>> 8;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_l     <= SAMPLE_ZERO;
            out_r     <= SAMPLE_ZERO;
        end else begin
            out_valid <= st1_valid;
            if (st1_valid) begin
                out_l <= to_offset(sat8(sh_l));
                out_r <= to_offset(sat8(sh_r));
            end
        end
    end

endmodule

// File: tb/tb_lmc1992_rx.sv
// Directed bench for lmc1992_rx: a frame/sample vector table plus hand-written
// sequences for bit-count, timing, pipeline and reset corner cases.
module tb_lmc1992_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       mw_bit_en, mw_mask, mw_data, mw_done;
    logic       sample_en;
    logic [7:0] dma_l, dma_r, psg;
    logic [7:0] out_l, out_r;
    logic       out_valid, cmd_valid, cmd_err;
    logic [5:0] master_vol;
    logic [4:0] left_vol, right_vol;
    logic [3:0] bass, treble;
    logic [1:0] mixer;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lmc1992_rx dut (
        .clk(clk), .reset(reset),
        .mw_bit_en(mw_bit_en), .mw_mask(mw_mask), .mw_data(mw_data), .mw_done(mw_done),
        .sample_en(sample_en), .dma_l(dma_l), .dma_r(dma_r), .psg(psg),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .cmd_valid(cmd_valid), .cmd_err(cmd_err),
        .master_vol(master_vol), .left_vol(left_vol), .right_vol(right_vol),
        .bass(bass), .treble(treble), .mixer(mixer)
    );

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic        err;
        logic [5:0]  m;
        logic [4:0]  l;
        logic [4:0]  r;
        logic [3:0]  b;
        logic [3:0]  t;
        logic [1:0]  x;
        logic [7:0]  dl;
        logic [7:0]  dr;
        logic [7:0]  ol;
        logic [7:0]  orr;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] regs_now();
        return 32'({master_vol, left_vol, right_vol, bass, treble, mixer});
    endfunction

    task automatic shift_bits(input logic [63:0] bits, input int n, input bit interleave);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            mw_bit_en = 1'b1; mw_mask = 1'b1; mw_data = bits[i];
            if (interleave) begin
                @(negedge clk);
                mw_bit_en = 1'b1; mw_mask = 1'b0; mw_data = ~bits[i];
            end
        end
    endtask

    task automatic close_frame(input logic bit_en, input logic bit_val,
                               input logic exp_valid, input logic exp_err, input string name);
        @(negedge clk);
        mw_bit_en = bit_en; mw_mask = bit_en; mw_data = bit_val; mw_done = 1'b1;
        @(negedge clk);
        mw_bit_en = 1'b0; mw_mask = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
        check({name, "_early"}, 32'({cmd_valid, cmd_err}), 32'b00);
        @(negedge clk);
        check(name, 32'({cmd_valid, cmd_err}), 32'({exp_valid, exp_err}));
        @(negedge clk);
        check({name, "_late"}, 32'({cmd_valid, cmd_err}), 32'b00);
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n,
                              input logic exp_valid, input logic exp_err, input string name);
        shift_bits(bits, n, 1'b0);
        close_frame(1'b0, 1'b0, exp_valid, exp_err, name);
    endtask

    task automatic sample(input logic [7:0] l, input logic [7:0] r,
                          input logic [7:0] el, input logic [7:0] er, input string name);
        @(negedge clk);
        sample_en = 1'b1; dma_l = l; dma_r = r;
        @(negedge clk);
        sample_en = 1'b0;
        check({name, "_valid_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_out"}, 32'({out_l, out_r}), 32'({el, er}));
    endtask

    initial begin
        vecs = '{
            '{16'h04E8, 11, 1'b0, 6'd40, 5'd20, 5'd20, 4'd6,  4'd6, 2'd1, 8'hFF, 8'h00, 8'hFF, 8'h00},
            '{16'h044F, 11, 1'b0, 6'd40, 5'd20, 5'd20, 4'd12, 4'd6, 2'd1, 8'hC0, 8'h40, 8'hC0, 8'h40},
            '{16'h0483, 11, 1'b0, 6'd40, 5'd20, 5'd20, 4'd12, 4'd3, 2'd1, 8'h81, 8'h7F, 8'h81, 8'h7F},
            '{16'h0402, 11, 1'b0, 6'd40, 5'd20, 5'd20, 4'd12, 4'd3, 2'd2, 8'h80, 8'h80, 8'h80, 8'h80},
            '{16'h04DE, 11, 1'b0, 6'd30, 5'd20, 5'd20, 4'd12, 4'd3, 2'd2, 8'hFF, 8'h00, 8'h8C, 8'h73},
            '{16'h0554, 11, 1'b0, 6'd30, 5'd20, 5'd20, 4'd12, 4'd3, 2'd2, 8'h80, 8'h40, 8'h80, 8'h79},
            '{16'h050A, 11, 1'b0, 6'd30, 5'd20, 5'd10, 4'd12, 4'd3, 2'd2, 8'h00, 8'hFF, 8'h73, 8'h81},
            '{16'h02C0, 11, 1'b1, 6'd30, 5'd20, 5'd10, 4'd12, 4'd3, 2'd2, 8'hFF, 8'h00, 8'h8C, 8'h7E},
            '{16'h0581, 11, 1'b1, 6'd30, 5'd20, 5'd10, 4'd12, 4'd3, 2'd2, 8'h90, 8'h80, 8'h81, 8'h80},
            '{16'h00E8,  9, 1'b1, 6'd30, 5'd20, 5'd10, 4'd12, 4'd3, 2'd2, 8'hFF, 8'hFF, 8'h8C, 8'h81},
            '{16'h04FF, 11, 1'b0, 6'd40, 5'd20, 5'd10, 4'd12, 4'd3, 2'd2, 8'hFF, 8'hFF, 8'hFF, 8'h8C},
            '{16'h0545, 11, 1'b0, 6'd40, 5'd5,  5'd10, 4'd12, 4'd3, 2'd2, 8'hFF, 8'h00, 8'h83, 8'h73},
            '{16'h04C0, 11, 1'b0, 6'd0,  5'd5,  5'd10, 4'd12, 4'd3, 2'd2, 8'hFF, 8'h00, 8'h80, 8'h80},
            '{16'h051F, 11, 1'b0, 6'd0,  5'd5,  5'd20, 4'd12, 4'd3, 2'd2, 8'h00, 8'hFF, 8'h80, 8'h80},
            '{16'h05C0, 11, 1'b1, 6'd0,  5'd5,  5'd20, 4'd12, 4'd3, 2'd2, 8'hFF, 8'hFF, 8'h80, 8'h80}
        };

        reset = 1'b1;
        mw_bit_en = 1'b0; mw_mask = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
        sample_en = 1'b0; dma_l = 8'h80; dma_r = 8'h80; psg = 8'h80;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_regs", regs_now(),
              32'({6'd40, 5'd20, 5'd20, 4'd6, 4'd6, 2'b01}));
        check("reset_out", 32'({out_l, out_r}), 32'h8080);
        check("reset_pulses", 32'({out_valid, cmd_valid, cmd_err}), 32'd0);

        for (int i = 0; i < 15; i++) begin
            send_frame(64'(vecs[i].frame), vecs[i].nbits, ~vecs[i].err, vecs[i].err,
                       $sformatf("vec%0d_cmd", i));
            check($sformatf("vec%0d_regs", i), regs_now(),
                  32'({vecs[i].m, vecs[i].l, vecs[i].r, vecs[i].b, vecs[i].t, vecs[i].x}));
            sample(vecs[i].dl, vecs[i].dr, vecs[i].ol, vecs[i].orr, $sformatf("vec%0d_smp", i));
        end

        // Last bit of master=20 arrives together with the closing edge.
        shift_bits(64'h26A, 10, 1'b0);
        close_frame(1'b1, 1'b0, 1'b1, 1'b0, "coincident_cmd");
        check("coincident_master", 32'(master_vol), 32'd20);
        sample(8'hFF, 8'hFF, 8'h80, 8'h81, "coincident_smp");

        // 16 masked bits with unmasked noise between them.
        shift_bits(64'hFD54, 16, 1'b1);
        close_frame(1'b0, 1'b0, 1'b1, 1'b0, "long16_cmd");
        check("long16_left", 32'(left_vol), 32'd20);
        sample(8'hFF, 8'hFF, 8'h81, 8'h81, "long16_smp");

        send_frame(64'h545, 11, 1'b1, 1'b0, "left5_cmd");
        check("left5_left", 32'(left_vol), 32'd5);
        send_frame(64'h0D5F, 13, 1'b1, 1'b0, "long13_cmd");
        check("long13_left", 32'(left_vol), 32'd20);

        // Count must saturate rather than wrap below 11.
        send_frame(64'hFFFF_FFFF_FFFF_FD45, 40, 1'b1, 1'b0, "long40_cmd");
        check("long40_left", 32'(left_vol), 32'd5);

        send_frame(64'h4E8, 11, 1'b1, 1'b0, "m40_cmd");
        @(negedge clk);
        sample_en = 1'b1; dma_l = 8'hFF; dma_r = 8'h00;
        @(negedge clk);
        dma_l = 8'h00; dma_r = 8'hC0;
        check("b2b_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        sample_en = 1'b0;
        check("b2b_valid1", 32'(out_valid), 32'd1);
        check("b2b_out_a", 32'({out_l, out_r}), 32'h8300);
        @(negedge clk);
        check("b2b_valid2", 32'(out_valid), 32'd1);
        check("b2b_out_b", 32'({out_l, out_r}), 32'h7CC0);
        @(negedge clk);
        check("b2b_valid3", 32'(out_valid), 32'd0);

        // Master drops to 0 while a sample is in flight; the old gain applies.
        shift_bits(64'h4C0, 11, 1'b0);
        @(negedge clk);
        mw_bit_en = 1'b0; mw_mask = 1'b0; mw_done = 1'b1;
        sample_en = 1'b1; dma_l = 8'hFF; dma_r = 8'hFF;
        @(negedge clk);
        mw_done = 1'b0; sample_en = 1'b0;
        @(negedge clk);
        check("inflight_cmd", 32'({cmd_valid, cmd_err}), 32'b10);
        check("inflight_valid", 32'(out_valid), 32'd1);
        check("inflight_out", 32'({out_l, out_r}), 32'h83FF);
        check("inflight_master", 32'(master_vol), 32'd0);

        // Reset lands on a pending frame close and an in-flight sample.
        shift_bits(64'h4CA, 11, 1'b0);
        @(negedge clk);
        mw_bit_en = 1'b0; mw_mask = 1'b0; mw_done = 1'b1;
        sample_en = 1'b1; dma_l = 8'hFF; dma_r = 8'hFF;
        @(negedge clk);
        mw_done = 1'b0; sample_en = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_cmd", 32'({cmd_valid, cmd_err}), 32'b00);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rst_mid_cmd2", 32'({cmd_valid, cmd_err}), 32'b00);
        check("rst_mid_valid2", 32'(out_valid), 32'd0);
        check("rst_mid_out", 32'({out_l, out_r}), 32'h8080);
        check("rst_mid_regs", regs_now(),
              32'({6'd40, 5'd20, 5'd20, 4'd6, 4'd6, 2'b01}));

        psg = 8'hF0;
`ifdef LMC1992_MIXER_EN
        sample(8'hF0, 8'hF0, 8'hFF, 8'hFF, "mix01_sat");
        send_frame(64'h402, 11, 1'b1, 1'b0, "mix10_cmd");
        sample(8'hF0, 8'hF0, 8'hF0, 8'hF0, "mix10_smp");
        send_frame(64'h400, 11, 1'b1, 1'b0, "mix00_cmd");
        psg = 8'h90;
        sample(8'h90, 8'h90, 8'h94, 8'h94, "mix00_smp");
`else
        sample(8'hF0, 8'hF0, 8'hF0, 8'hF0, "psg_ignored");
        send_frame(64'h400, 11, 1'b1, 1'b0, "mix00_cmd");
        check("mix00_reg", 32'(mixer), 32'd0);
        sample(8'h90, 8'h90, 8'h90, 8'h90, "psg_ignored00");
`endif
        psg = 8'h80;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lmc1992_rx.md
# lmc1992_rx

Receive-side model of the LMC1992 volume/tone controller that sits at the far end of the STE microwire link. It deserialises the masked bit stream from the DMA-sound microwire shifter and decodes 11-bit LMC1992 commands into master, left, right, bass, treble and mixer registers. It applies the resulting attenuation to the 8-bit DMA audio samples before they reach the audio DAC path. Bass and treble are stored and exported only; no tone filtering is performed.

## Interface
Parameters:
- `LMC_ADDR`, default 2'b10: device address that must match bits [10:9] of a frame.

Ports:
- `clk`  in  1  system clock (32 MHz).
- `reset`  in  1  synchronous, active-high.
- `mw_bit_en`  in  1  one-cycle strobe per microwire bit time.
- `mw_mask`  in  1  bit qualifier; the bit is valid only when 1 at `mw_bit_en`.
- `mw_data`  in  1  serial data, MSB first.
- `mw_done`  in  1  high at end of transfer; the rising edge closes the frame.
- `sample_en`  in  1  one-cycle strobe; new sample on `dma_l`/`dma_r`.
- `dma_l`, `dma_r`  in  8 each  unsigned samples, offset binary, 128 = zero.
- `psg`  in  8  unsigned YM audio. Used only with `LMC1992_MIXER_EN`.
- `out_l`, `out_r`  out  8 each  attenuated samples, offset binary.
- `out_valid`  out  1  one-cycle pulse when `out_l`/`out_r` update.
- `cmd_valid`  out  1  one-cycle pulse when a command has been applied.
- `cmd_err`  out  1  one-cycle pulse when a frame has been rejected.
- `master_vol`  out  6  master volume, range 0..40.
- `left_vol`, `right_vol`  out  5 each  channel volume, range 0..20.
- `bass`, `treble`  out  4 each  range 0..12.
- `mixer`  out  2  mixer setting.

## Operation
- Reset values:
  - `master_vol` 40, `left_vol` 20, `right_vol` 20.
  - `bass` 6, `treble` 6, `mixer` 2'b01.
  - `out_l`/`out_r` 128.
  - `out_valid`, `cmd_valid`, `cmd_err` 0.
  - Shifter 0, bit count 0.
- Shifting: on `mw_bit_en && mw_mask`, shifter <= {shifter[9:0], mw_data}. The bit count increments and saturates at 31.
- Frame close: on a rising edge of `mw_done`, evaluate the frame, then clear the shifter and bit count.
- Frame rejection (`cmd_err`, no register change) when any of:
  - bit count < 11;
  - shifter[10:9] != `LMC_ADDR`;
  - function code 110 or 111.
- More than 11 bits: only the last 11 bits are used.
- Function decode uses [8:6]; data is [5:0]:
  - 000 → mixer <= d[1:0].
  - 001 → bass <= min(d[3:0], 12).
  - 010 → treble <= min(d[3:0], 12).
  - 011 → master <= min(d, 40).
  - 100 → right <= min(d[4:0], 20).
  - 101 → left <= min(d[4:0], 20).
- Gain arithmetic:
  - Per channel, k = (40 − master) + (20 − chan_vol), range 0..60, in 2 dB steps.
  - Gain lookup: g = round(256·10^(−k/10)), 9 bits, so g(0) = 256. For k ≥ 40, g = 0 (mute).
  - s = sample − 128, signed 8-bit.
  - y = (s·g) >>> 8, arithmetic shift, then saturate to −128..127.
  - out = y + 128.

## Timing
- Frame close to register update:
  - Cycle N: rising edge of `mw_done` is detected (registered edge detect).
  - Cycle N+1: registers update and `cmd_valid`/`cmd_err` pulse.
- `mw_bit_en` coincident with the `mw_done` rising edge: the bit is shifted in first and counts toward the frame.
- Sample pipeline, with `sample_en` at cycle S:
  - S+1: mixed sample and both k values registered.
  - S+2: product computed, `out_*` registered, `out_valid` pulses.
- A register change at S+1 or later does not affect the sample already in flight.
- Back-to-back `sample_en` is supported; throughput is 1 sample per cycle.
- Reset mid-frame discards the partial frame; no `cmd_err` is produced.
- Reset mid-sample discards the in-flight sample; no `out_valid` is produced.

## Configuration
- `LMC1992_MIXER_EN` defined:
  - p = psg − 128, mixed into each channel before attenuation.
  - Mixer 00 adds p>>>2 (−12 dB); 01 adds p; 10 and 11 add nothing.
  - The sum is 9-bit and saturated to signed 8-bit.
- `LMC1992_MIXER_EN` undefined:
  - `psg` is ignored and no PSG path is synthesised.
  - The `mixer` register is still decoded and exported.

## Structure
- Shared package `lmc1992_pkg` holds:
  - function-code constants (`LMC_FN_MIXER` … `LMC_FN_LEFT`);
  - reset constants;
  - range limits 40/20/12;
  - mute threshold 40.
- Sub-module `lmc1992_gain_rom`: combinational 6-bit k in, 9-bit g out, 41 entries with the mute default.

## Test plan
- Frame 0x4E8 (addr 10, fn 011, data 40) → master 40, `cmd_valid` one cycle after the `mw_done` edge; sample 0xFF → `out` 0xFF.
- Frames master=30 and left=20, then `dma_l` = 0xFF → k = 10, g = 26; `out_l` = 128 + ((127·26)>>8) = 140, 2 cycles after `sample_en`.
- 9-bit frame, or address 01 → `cmd_err`, all registers unchanged.
- 16 masked bits ending in 10_101_010100 → only the last 11 bits are used; left = 20 (clamped from 20); 13 masked bits ending in 10_101_011111 → left = 20 (clamped from 31).
- Master = 0 → both outputs constant 128 for any input.
- With `LMC1992_MIXER_EN`, mixer 01, dma 0xF0, psg 0xF0 at 0 dB → sum saturates → out 0xFF. Mixer 10 → out 0xF0.
